pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic handshaked pipeline stage register for the MIPS core. It holds the packed
//  inter-stage bundle (inst | operands | control | PC) and decodes the regfile write
//  address from a one-hot write-target and the instruction fields.
//  It replaces the hard-wired per-stage bundle logic and adds valid/ready flow control,
//  flush, an optional skid entry and a stall-cycle counter.
//  One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//  DATA_W  218  width of packed bundle; inst occupies in_data[DATA_W-1 -: 32]
//  SKID    0    0: single entry, combinational in_ready; 1: two entries, registered in_ready
//  CNT_W   16   width of stall-cycle counter
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous reset, active-high
//  flush      in   1       kill every entry held or being accepted this cycle
//  in_valid   in   1       upstream bundle valid
//  in_ready   out  1       stage can accept this cycle
//  in_data    in   DATA_W  upstream bundle
//  in_wen     in   1       bundle writes the regfile
//  in_wtgt    in   6       one-hot write target: [0]=rd, [4]=rt, [5]=$31, other bits unused
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream accepts head entry
//  out_data   out  DATA_W  head bundle
//  out_waddr  out  5       decoded regfile write address of head entry
//  out_wen    out  1       head entry writes the regfile (in_wen && waddr!=0)
//  stall_cnt  out  CNT_W   cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_waddr=0, out_wen=0, stall_cnt=0; in_ready=1 on the first cycle after reset.
//  Accept = in_valid && in_ready && !flush. Drain = out_valid && out_ready.
//  Decode happens at capture. inst=in_data[DATA_W-1 -: 32]; rd=inst[15:11], rt=inst[20:16].
//   waddr = ({5{wtgt[0]}}&rd) | ({5{wtgt[4]}}&rt) | ({5{wtgt[5]}}&5'd31).
//   Several set bits are OR-ed. No valid bit set gives waddr=0.
//   wen_q = in_wen && waddr!=0, so writes to $0 are suppressed.
//  SKID=0:
//   in_ready = !out_valid || out_ready (combinational).
//   On Accept: the entry loads and out_valid=1 next cycle, so latency is 1 cycle.
//   On Drain without Accept: out_valid=0.
//  SKID=1: main entry (head) plus skid entry; in_ready = !skid_valid (registered).
//   Accept while main empty, or while main drains with skid empty: load main.
//   Accept while main full and not draining: load skid.
//   Drain with skid full: skid moves to main; a same-cycle Accept is impossible (in_ready=0).
//   Order is preserved strictly FIFO. Throughput is 1/cycle with no bubble on continuous streams.
//  flush has priority over everything.
//   Next cycle: all valid bits=0 and out_wen=0. Any Accept in the flush cycle is dropped.
//   Data registers may keep stale values.
//   A downstream Drain in the flush cycle still counts as a handshake for downstream.
//   Only valid bits change; stall_cnt is not cleared by flush.
//  stall_cnt: +1 per cycle with out_valid && !out_ready. Holds at 2^CNT_W-1. Cleared only by rst.
//  out_data/out_waddr/out_wen are registered and hold while !out_ready (stable under stall).
//  rst mid-stream: all entries discarded, same values as reset.
// TESTING
//  T1 Reset: rst=1 for 2 cycles -> out_valid=0, stall_cnt=0, in_ready=1 (both SKID values).
//  T2 Decode: inst=32'h012A5820 (rd=11, rt=10), wtgt=6'b000001, wen=1 -> out_waddr=11, out_wen=1;
//     wtgt=6'b010000 -> waddr=10; wtgt=6'b100000 -> waddr=31; rd=0, wtgt[0] -> out_wen=0.
//  T3 Stream: 8 back-to-back bundles, out_ready=1 -> 8 outputs in order, 1-cycle latency, no gaps.
//  T4 Stall (SKID=1): out_ready=0 for 5 cycles while in_valid=1 -> 2 entries held,
//     in_ready=0 from cycle 2, stall_cnt=5; release -> both emitted in order, no loss or duplication.
//  T5 Flush: 2 entries held plus in_valid=1, flush=1 for one cycle -> next cycle out_valid=0,
//     flushed bundle never appears, stall_cnt unchanged.
//  T6 Saturation: CNT_W=4, out_ready=0 for 20 cycles with a valid head -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register for the MIPS core.
// Holds one inter-stage bundle (optionally two with SKID=1). The regfile
// write address is decoded from the instruction fields at capture time.
// A saturating counter records the cycles in which the head entry is stalled.
module pipe_stage_reg #(
  parameter int DATA_W = 218,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_wen,
  input  logic [5:0]        in_wtgt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_waddr,
  output logic              out_wen,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // One-hot write target: [0]=rd, [4]=rt, [5]=$31. Several set bits OR together.
  function automatic logic [4:0] decode_waddr(input logic [31:0] inst,
                                              input logic [5:0]  wtgt);
    return ({5{wtgt[0]}} & inst[15:11]) |
           ({5{wtgt[4]}} & inst[20:16]) |
           ({5{wtgt[5]}} & 5'd31);
  endfunction

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [4:0]        w_in_waddr;
  logic              w_in_wen;
  logic              w_accept;
  logic              w_drain;
  logic              w_load_skid;
  logic              w_load_head;
  logic              w_head_from_skid;

  logic              r_head_vld_p1;
  logic [DATA_W-1:0] r_head_data_p1;
  logic [4:0]        r_head_waddr_p1;
  logic              r_head_wen_p1;

  logic              r_skid_vld_p0;
  logic [DATA_W-1:0] r_skid_data_p0;
  logic [4:0]        r_skid_waddr_p0;
  logic              r_skid_wen_p0;

  logic [CNT_W-1:0]  r_stall_cnt;

  // ---- stage p0: capture-side decode and handshake qualification ----
  assign w_in_waddr = decode_waddr(in_data[DATA_W-1 -: 32], in_wtgt);
  assign w_in_wen   = in_wen && (w_in_waddr != 5'd0);

  // With a skid entry in_ready depends only on state (breaks the ready path);
  // without it, a draining head frees the slot in the same cycle.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = !r_skid_vld_p0;
    end else begin : g_comb_ready
      assign in_ready = !r_head_vld_p1 || out_ready;
    end
  endgenerate

  assign w_accept         = in_valid && in_ready && !flush;
  assign w_drain          = r_head_vld_p1 && out_ready;
  // The skid slot only fills when the head is occupied and not leaving.
  assign w_load_skid      = (SKID != 0) && w_accept && r_head_vld_p1 && !w_drain;
  assign w_load_head      = w_accept && !w_load_skid;
  // An occupied skid entry means in_ready=0, so no accept competes with this move.
  assign w_head_from_skid = w_drain && r_skid_vld_p0;

  // Valid bits: flush clears both entries and drops any same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_vld_p1 <= 1'b0;
      r_skid_vld_p0 <= 1'b0;
    end else if (flush) begin
      r_head_vld_p1 <= 1'b0;
      r_skid_vld_p0 <= 1'b0;
    end else begin
      if (w_head_from_skid || w_load_head) begin
        r_head_vld_p1 <= 1'b1;
      end else if (w_drain) begin
        r_head_vld_p1 <= 1'b0;
      end
      if (w_load_skid) begin
        r_skid_vld_p0 <= 1'b1;
      end else if (w_head_from_skid) begin
        r_skid_vld_p0 <= 1'b0;
      end
    end
  end

  // ---- stage p1: head entry, fed from the skid entry first to keep FIFO order ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_data_p1  <= '0;
      r_head_waddr_p1 <= 5'd0;
      r_head_wen_p1   <= 1'b0;
    end else if (w_head_from_skid) begin
      r_head_data_p1  <= r_skid_data_p0;
      r_head_waddr_p1 <= r_skid_waddr_p0;
      r_head_wen_p1   <= r_skid_wen_p0;
    end else if (w_load_head) begin
      r_head_data_p1  <= in_data;
      r_head_waddr_p1 <= w_in_waddr;
      r_head_wen_p1   <= w_in_wen;
    end
  end

  // Skid entry payload; its valid bit alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_data_p0  <= in_data;
      r_skid_waddr_p0 <= w_in_waddr;
      r_skid_wen_p0   <= w_in_wen;
    end
  end

  // Stall-cycle counter: only rst clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_head_vld_p1 && !out_ready) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign out_valid = r_head_vld_p1;
  assign out_data  = r_head_data_p1;
  assign out_waddr = r_head_waddr_p1;
  // Qualified by valid so a flushed or drained head never advertises a write.
  assign out_wen   = r_head_vld_p1 && r_head_wen_p1;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one single-entry instance (u0) and one
// skid instance with a 4-bit stall counter (u1) share the same stimulus.
module tb_pipe_stage_reg;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_wen, out_ready;
  logic [DW-1:0] in_data;
  logic [5:0]    in_wtgt;

  logic          rdy0, vld0, we0;
  logic [DW-1:0] dat0;
  logic [4:0]    wa0;
  logic [15:0]   cnt0;

  logic          rdy1, vld1, we1;
  logic [DW-1:0] dat1;
  logic [4:0]    wa1;
  logic [3:0]    cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] INST_A = 32'h012A5820; // rd=11, rt=10
  localparam logic [31:0] INST_Z = 32'h012A0020; // rd=0,  rt=10
  localparam logic [DW-1:0] BX = {INST_A, 32'h1111_0001};
  localparam logic [DW-1:0] BY = {INST_A, 32'h2222_0002};
  localparam logic [DW-1:0] BZ = {INST_A, 32'h3333_0003};

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_wen(in_wen), .in_wtgt(in_wtgt), .out_valid(vld0),
    .out_ready(out_ready), .out_data(dat0), .out_waddr(wa0), .out_wen(we0),
    .stall_cnt(cnt0)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_wen(in_wen), .in_wtgt(in_wtgt), .out_valid(vld1),
    .out_ready(out_ready), .out_data(dat1), .out_waddr(wa1), .out_wen(we1),
    .stall_cnt(cnt1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i);
    return {INST_A, 24'hC0DE00, 8'(i)};
  endfunction

  task automatic do_dec(input string tag, input logic [31:0] inst, input logic [5:0] wtgt,
                        input logic wen, input logic [4:0] exp_wa, input logic exp_we);
    in_valid  = 1'b1;
    in_data   = {inst, 32'hA5A5_5A5A};
    in_wtgt   = wtgt;
    in_wen    = wen;
    out_ready = 1'b1;
    step();
    chk({tag, "_vld0"}, 64'(vld0), 64'd1);
    chk({tag, "_wa0"},  64'(wa0),  64'(exp_wa));
    chk({tag, "_we0"},  64'(we0),  64'(exp_we));
    chk({tag, "_wa1"},  64'(wa1),  64'(exp_wa));
    chk({tag, "_we1"},  64'(we1),  64'(exp_we));
    in_valid = 1'b0;
    step();
    chk({tag, "_empty1"}, 64'(vld1), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_wen = 1'b0; out_ready = 1'b0;
    in_data = '0; in_wtgt = 6'd0;

    // T1 reset held for two cycles
    step(); step();
    chk("rst_vld0",  64'(vld0), 64'd0);
    chk("rst_vld1",  64'(vld1), 64'd0);
    chk("rst_cnt0",  64'(cnt0), 64'd0);
    chk("rst_cnt1",  64'(cnt1), 64'd0);
    chk("rst_dat1",  dat1,      64'd0);
    chk("rst_wa0",   64'(wa0),  64'd0);
    chk("rst_we1",   64'(we1),  64'd0);
    rst = 1'b0;
    chk("rst_rdy0",  64'(rdy0), 64'd1);
    chk("rst_rdy1",  64'(rdy1), 64'd1);

    // T2 write-address decode
    do_dec("dec_rd",   INST_A, 6'b000001, 1'b1, 5'd11, 1'b1);
    do_dec("dec_rt",   INST_A, 6'b010000, 1'b1, 5'd10, 1'b1);
    do_dec("dec_r31",  INST_A, 6'b100000, 1'b1, 5'd31, 1'b1);
    do_dec("dec_zero", INST_Z, 6'b000001, 1'b1, 5'd0,  1'b0);
    do_dec("dec_or",   INST_A, 6'b010001, 1'b1, 5'd11, 1'b1);
    do_dec("dec_none", INST_A, 6'b000010, 1'b1, 5'd0,  1'b0);
    do_dec("dec_nowen",INST_A, 6'b000001, 1'b0, 5'd11, 1'b0);

    // T3 back-to-back stream, 1-cycle latency, no gaps
    in_wtgt = 6'b000001; in_wen = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = mk(i);
      chk("str_rdy1", 64'(rdy1), 64'd1);
      step();
      chk("str_vld0", 64'(vld0), 64'd1);
      chk("str_dat0", dat0, mk(i));
      chk("str_vld1", 64'(vld1), 64'd1);
      chk("str_dat1", dat1, mk(i));
    end
    in_valid = 1'b0;
    step();
    chk("str_end0", 64'(vld0), 64'd0);
    chk("str_end1", 64'(vld1), 64'd0);

    // T4 stall on the skid instance
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b1; in_data = BX; out_ready = 1'b0;
    step();
    chk("stl_head", dat1, BX);
    chk("stl_rdyA", 64'(rdy1), 64'd1);
    in_data = BY;
    step();
    chk("stl_rdyB", 64'(rdy1), 64'd0);
    chk("stl_cnt1", 64'(cnt1), 64'd1);
    in_data = BZ;
    step(); step(); step(); step();
    chk("stl_cnt5", 64'(cnt1), 64'd5);
    chk("stl_rdyC", 64'(rdy1), 64'd0);
    chk("stl_hold", dat1, BX);
    chk("stl_vld",  64'(vld1), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("stl_out2", dat1, BY);
    chk("stl_vld2", 64'(vld1), 64'd1);
    chk("stl_rdyD", 64'(rdy1), 64'd1);
    chk("stl_cntK", 64'(cnt1), 64'd5);
    step();
    chk("stl_done", 64'(vld1), 64'd0);

    // T5 flush with two entries held and an incoming bundle
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 1'b1; in_data = BX; out_ready = 1'b0;
    step();
    in_data = BY;
    step();
    chk("fl_pre_cnt", 64'(cnt1), 64'd1);
    in_data = BZ; flush = 1'b1; out_ready = 1'b1;
    step();
    chk("fl_vld1", 64'(vld1), 64'd0);
    chk("fl_we1",  64'(we1),  64'd0);
    chk("fl_vld0", 64'(vld0), 64'd0);
    chk("fl_cnt1", 64'(cnt1), 64'd1);
    chk("fl_rdy1", 64'(rdy1), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl_gone1", 64'(vld1), 64'd0);
    step();
    chk("fl_gone2", 64'(vld1), 64'd0);
    // flush into an empty stage drops the accept
    in_valid = 1'b1; in_data = BZ; flush = 1'b1;
    step();
    chk("fl_drop0", 64'(vld0), 64'd0);
    chk("fl_drop1", 64'(vld1), 64'd0);
    flush = 1'b0; in_valid = 1'b0;

    // mid-stream reset discards held entries
    in_valid = 1'b1; in_data = BX; out_ready = 1'b0;
    step(); step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("mrst_vld1", 64'(vld1), 64'd0);
    chk("mrst_cnt1", 64'(cnt1), 64'd0);
    chk("mrst_rdy1", 64'(rdy1), 64'd1);
    chk("mrst_dat1", dat1,      64'd0);
    chk("mrst_wa1",  64'(wa1),  64'd0);

    // T6 counter saturation (u1 has a 4-bit counter)
    in_valid = 1'b1; in_data = BX; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (14) step();
    chk("sat_cnt14",  64'(cnt1), 64'd14);
    chk("sat_cnt0a",  64'(cnt0), 64'd14);
    step();
    chk("sat_cnt15",  64'(cnt1), 64'd15);
    repeat (5) step();
    chk("sat_hold",   64'(cnt1), 64'd15);
    chk("sat_cnt0b",  64'(cnt0), 64'd20);
    chk("sat_dat",    dat1,      BX);
    out_ready = 1'b1;
    step();
    chk("sat_drain",  64'(vld1), 64'd0);
    chk("sat_keep",   64'(cnt1), 64'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
